serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Serial-to-parallel receiver. Collects a qualified serial bit stream into W-bit words and presents each completed word on a one-deep output buffer with a valid/ready handshake. Pairs with the parallel-load serial shifter that drives the other end of the link: that shifter's right-shift mode corresponds to LSB-first here, and its left-shift mode corresponds to MSB-first. Sits between the serial link pins/fabric and the word-level consumer. It also flags frame errors and overruns.

## Interface
- W, 16, word width in bits; W ≥ 2
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- frame_start  in  1  discard any partial word; the next accepted bit is bit 0 of a new word
- bit_valid  in  1  serial_in is valid this cycle
- serial_in  in  1  serial data bit
- lsb_first  in  1  1: first bit received → word bit 0 (right shift); 0: first bit → word bit W-1 (left shift)
- word_out  out  W  completed word; stable while word_valid=1
- word_valid  out  1  output buffer holds an unconsumed word
- word_ready  in  1  consumer accepts word_out when word_valid & word_ready
- bit_count  out  $clog2(W+1)  bits collected in the current partial word (0..W-1)
- overrun  out  1  sticky: a completed word was dropped because the buffer was full
- frame_error  out  1  sticky: frame_start arrived with a partial word (bit_count ≠ 0)
- clear_flags  in  1  synchronous clear of overrun and frame_error

## Operation
- FSM states are IDLE and COLLECT.
  - IDLE: bit_count = 0. An accepted bit (bit_valid) → COLLECT. The mode is latched from lsb_first at that bit.
  - COLLECT: each accepted bit increments bit_count. The W-th bit completes the word and returns the FSM to IDLE (bit_count → 0).
- Shift register:
  - lsb_first latched 1: sr <= {serial_in, sr[W-1:1]}.
  - Latched 0: sr <= {sr[W-2:0], serial_in}.
  - lsb_first is ignored mid-word.
- Completion: the completed word is formed from the shift register including the current bit. It is written to the output buffer if the buffer is empty, or being consumed this same cycle. Otherwise the word is dropped, the buffer keeps the old word, and overrun is set.
- Consumption: on word_valid & word_ready with no completion in that cycle, word_valid → 0.
- frame_start has priority over bit_valid in the same cycle:
  - Partial word is discarded and the FSM goes to IDLE with bit_count 0.
  - frame_error is set if bit_count ≠ 0.
  - A bit_valid in the same cycle is ignored.
  - The output buffer is unaffected.
- Flag priority: clear_flags with a same-cycle set event leaves the flag set (set wins).
- Reset mid-word: the partial word is lost and the output buffer is emptied.

## Timing
- Reset values: word_out = 0, word_valid = 0, bit_count = 0, overrun = 0, frame_error = 0, FSM = IDLE, shift register = 0, latched mode = 0.
- Latency: word_valid rises on the clock edge that samples the W-th bit, i.e. it is visible the cycle after that bit.
- Throughput: back-to-back words with bit_valid held high every cycle, one bit per cycle, no gaps.
- Handshake:
  - word_out and word_valid are registered; neither depends combinationally on word_ready.
  - Completion and consumption in the same cycle → the new word is loaded and word_valid stays 1.
- bit_count is registered and updates on each accepted bit.

## Structure
- Shared package contents:
  - FSM state typedef (IDLE, COLLECT).
  - Bit-order constants LSB_FIRST = 1, MSB_FIRST = 0, shared with the transmit shifter.
- Sub-module rx_shift_core:
  - Direction-selectable W-bit serial-in shift register with a clear input.
  - The top level holds the FSM, counter, output buffer and flags.

## Test plan
- **LSB-first word:** W = 16, lsb_first = 1. Send 0xA5C3 LSB-first on 16 consecutive cycles. Required: word_out = 0xA5C3 and word_valid = 1 the cycle after the last bit.
- **MSB-first word:** send the same value MSB-first with lsb_first = 0. Required: word_out = 0xA5C3. Toggling lsb_first at bit 5 has no effect on the result.
- **Back-to-back with same-cycle handshake:** send 0x1234 then 0xFFFF continuously with word_ready = 1. Required: two consecutive words, with no overrun.
- **Overrun:** hold word_ready = 0 and send 0x1111 then 0x2222. Required: word_out stays 0x1111 and overrun = 1. clear_flags then clears overrun.
- **Frame error and same-cycle bit:** send 7 bits, then frame_start. Required: bit_count = 0 and frame_error = 1. A bit_valid in the frame_start cycle is not counted, and the next 16 bits form a correct word.
- **Reset mid-word and flag priority:** assert reset after 9 bits, then release. Required: all outputs at reset values and the next word is received correctly. Separately, assert clear_flags together with an overrun event: overrun remains 1.

Source files
------------

// File: rtl/serial_word_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_receiver_pkg
// Shared definitions for the serial word receiver and its shift core.
//   rx_state_t : receiver FSM states
//   LSB_FIRST  : first received bit lands in word bit 0 (transmit right shift)
//   MSB_FIRST  : first received bit lands in word bit W-1 (transmit left shift)
// The bit-order constants are common with the transmit-side shifter so both
// ends of the link agree on what a lsb_first value of 1 or 0 means.
// -----------------------------------------------------------------------------
package serial_word_receiver_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    localparam logic LSB_FIRST = 1'b1;
    localparam logic MSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_word_receiver_shift_core.sv
// -----------------------------------------------------------------------------
// rx_shift_core
// Direction-selectable W-bit serial-in shift register.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous clear of the register (wins over shift_en)
//   shift_en     : shift serial_in in this cycle
//   lsb_first    : LSB_FIRST shifts right (new bit at MSB), MSB_FIRST shifts left
//   serial_in    : serial data bit
//   word_next    : register contents after shifting in serial_in this cycle;
//                  lets the caller capture a completed word on the same edge
// -----------------------------------------------------------------------------
module rx_shift_core
    import serial_word_receiver_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         lsb_first,
    input  logic         serial_in,
    output logic [W-1:0] word_next
);

    logic [W-1:0] sr;

    always_comb begin
        if (lsb_first == LSB_FIRST)
            word_next = {serial_in, sr[W-1:1]};
        else
            word_next = {sr[W-2:0], serial_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sr <= '0;
        else if (clear)
            sr <= '0;
        else if (shift_en)
            sr <= word_next;
    end

endmodule

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
// Collects a qualified serial bit stream into W-bit words and presents each
// completed word in a one-deep output buffer with a valid/ready handshake.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   frame_start  : abandon any partial word; next accepted bit starts a word
//   bit_valid    : serial_in carries a bit this cycle
//   serial_in    : serial data bit
//   lsb_first    : bit order, sampled on the first bit of each word
//   word_out     : completed word, held while word_valid is high
//   word_valid   : output buffer holds an unconsumed word
//   word_ready   : consumer takes word_out when word_valid & word_ready
//   bit_count    : bits collected in the current partial word
//   overrun      : sticky, a completed word was dropped (buffer full)
//   frame_error  : sticky, frame_start cut a partial word short
//   clear_flags  : synchronous clear of overrun and frame_error
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no partial word; next accepted bit is bit 0 and latches mode
// COLLECT | partial word in progress; bit order locked to latched mode
// -----------------------------------------------------------------------------
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   bit_valid,
    input  logic                   serial_in,
    input  logic                   lsb_first,
    output logic [W-1:0]           word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [$clog2(W+1)-1:0] bit_count,
    output logic                   overrun,
    output logic                   frame_error,
    input  logic                   clear_flags
);

    localparam int CW = $clog2(W + 1);

    rx_state_t    state, state_next;
    logic         mode_q;
    logic         shift_dir;
    logic         accept;
    logic         complete;
    logic         load_buf;
    logic         overrun_set;
    logic         frame_error_set;
    logic [W-1:0] word_next;

    // frame_start masks a same-cycle bit entirely.
    assign accept          = bit_valid & ~frame_start;
    assign complete        = accept && (bit_count == CW'(W - 1));
    assign load_buf        = complete && (!word_valid || word_ready);
    assign overrun_set     = complete && word_valid && !word_ready;
    assign frame_error_set = frame_start && (bit_count != '0);

    // The first bit of a word must already follow the incoming lsb_first,
    // since mode_q only takes that value on the same edge.
    assign shift_dir = (state == IDLE) ? lsb_first : mode_q;

    rx_shift_core #(.W(W)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .clear     (frame_start | complete),
        .shift_en  (accept),
        .lsb_first (shift_dir),
        .serial_in (serial_in),
        .word_next (word_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    state_next = COLLECT;
                COLLECT: state_next = complete ? IDLE : COLLECT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bit_count <= '0;
        else if (frame_start || complete)
            bit_count <= '0;
        else if (accept)
            bit_count <= bit_count + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mode_q <= MSB_FIRST;
        else if (accept && state == IDLE)
            mode_q <= lsb_first;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (load_buf) begin
            word_out   <= word_next;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    // A set event in the same cycle as clear_flags keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (clear_flags)
                overrun <= 1'b0;
            if (frame_error_set)
                frame_error <= 1'b1;
            else if (clear_flags)
                frame_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic          bit_valid = 1'b0;
    logic          serial_in = 1'b0;
    logic          lsb_first = 1'b0;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [CW-1:0] bit_count;
    logic          overrun;
    logic          frame_error;
    logic          clear_flags = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: bits received so far, in arrival order.
    bit          m_bits[$];
    bit          m_mode;
    logic [W-1:0] m_word;
    bit          m_valid;
    bit          m_ovr;
    bit          m_ferr;

    serial_word_receiver #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .serial_in   (serial_in),
        .lsb_first   (lsb_first),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .bit_count   (bit_count),
        .overrun     (overrun),
        .frame_error (frame_error),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":word_valid"},  32'(word_valid),  32'(m_valid));
        chk({tag, ":word_out"},    32'(word_out),    32'(m_word));
        chk({tag, ":bit_count"},   32'(bit_count),   32'(m_bits.size()));
        chk({tag, ":overrun"},     32'(overrun),     32'(m_ovr));
        chk({tag, ":frame_error"}, 32'(frame_error), 32'(m_ferr));
    endtask

    // Apply one cycle of inputs (called at a falling edge), advance the
    // model by the receiver rules, then compare at the next falling edge.
    task automatic cycle(input bit fs, input bit bv, input bit si, input bit lsb,
                         input bit rdy, input bit clr, input string tag);
        bit loaded, ovr_set, ferr_set;
        logic [W-1:0] w;
        frame_start = fs; bit_valid = bv; serial_in = si;
        lsb_first = lsb; word_ready = rdy; clear_flags = clr;
        loaded = 0; ovr_set = 0; ferr_set = 0;
        if (fs) begin
            if (m_bits.size() != 0) ferr_set = 1;
            m_bits.delete();
        end else if (bv) begin
            if (m_bits.size() == 0) m_mode = lsb;
            m_bits.push_back(si);
            if (m_bits.size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) begin
                    if (m_mode) w[i] = m_bits[i];
                    else        w[W-1-i] = m_bits[i];
                end
                if (!m_valid || rdy) begin
                    m_word = w; m_valid = 1; loaded = 1;
                end else begin
                    ovr_set = 1;
                end
                m_bits.delete();
            end
        end
        if (!loaded && m_valid && rdy) m_valid = 0;
        m_ovr  = ovr_set  ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_ferr = ferr_set ? 1'b1 : (clr ? 1'b0 : m_ferr);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input bit rdy, input bit clr);
        cycle(0, 0, 0, 0, rdy, clr, "idle");
    endtask

    // Send a full word; the wire order follows 'lsb'. From bit index
    // toggle_at onward lsb_first is driven inverted (should be ignored).
    task automatic send_word(input logic [W-1:0] val, input bit lsb, input bit rdy,
                             input int toggle_at, input bit clr_last, input string tag);
        for (int i = 0; i < W; i++) begin
            bit b, l;
            b = lsb ? val[i] : val[W-1-i];
            l = (i >= toggle_at) ? ~lsb : lsb;
            cycle(0, 1, b, l, rdy, (i == W-1) ? clr_last : 1'b0, tag);
        end
    endtask

    task automatic do_reset();
        frame_start = 0; bit_valid = 0; serial_in = 0; lsb_first = 0;
        word_ready = 0; clear_flags = 0;
        reset = 1;
        m_bits.delete(); m_mode = 0; m_word = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check_all("post_reset");
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // LSB-first word
        send_word(16'hA5C3, 1, 0, W, 0, "lsb_word");
        chk("lsb_word_value", 32'(word_out), 32'h0000_A5C3);
        chk("lsb_word_valid", 32'(word_valid), 32'd1);
        idle(1, 0);

        // MSB-first word with lsb_first toggled from bit 5
        send_word(16'hA5C3, 0, 0, 5, 0, "msb_word");
        chk("msb_word_value", 32'(word_out), 32'h0000_A5C3);
        idle(1, 0);

        // Back-to-back with same-cycle handshake
        send_word(16'h1234, 1, 1, W, 0, "b2b_first");
        chk("b2b_first_value", 32'(word_out), 32'h0000_1234);
        send_word(16'hFFFF, 0, 1, W, 0, "b2b_second");
        chk("b2b_second_value", 32'(word_out), 32'h0000_FFFF);
        chk("b2b_second_valid", 32'(word_valid), 32'd1);
        chk("b2b_no_overrun", 32'(overrun), 32'd0);
        idle(1, 0);

        // Overrun, then clear
        send_word(16'h1111, 1, 0, W, 0, "ovr_first");
        send_word(16'h2222, 1, 0, W, 0, "ovr_second");
        chk("ovr_word_kept", 32'(word_out), 32'h0000_1111);
        chk("ovr_flag", 32'(overrun), 32'd1);
        idle(0, 1);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        idle(1, 0);

        // Frame error, with a bit in the frame_start cycle
        for (int i = 0; i < 7; i++) cycle(0, 1, 1'(i & 1), 1, 0, 0, "ferr_bits");
        cycle(1, 1, 1, 1, 0, 0, "ferr_start");
        chk("ferr_count", 32'(bit_count), 32'd0);
        chk("ferr_flag", 32'(frame_error), 32'd1);
        send_word(16'h5A0F, 1, 0, W, 0, "ferr_next");
        chk("ferr_next_value", 32'(word_out), 32'h0000_5A0F);
        idle(1, 1);
        chk("ferr_cleared", 32'(frame_error), 32'd0);

        // Reset mid-word
        for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, 0, 0, "rst_bits");
        do_reset();
        send_word(16'hC0DE, 0, 0, W, 0, "rst_next");
        chk("rst_next_value", 32'(word_out), 32'h0000_C0DE);

        // clear_flags together with an overrun event: set wins
        send_word(16'h3333, 1, 0, W, 1, "prio_word");
        chk("prio_overrun", 32'(overrun), 32'd1);
        chk("prio_word_kept", 32'(word_out), 32'h0000_C0DE);
        idle(1, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit fs, bv, si, l, r, c;
            fs = ($urandom_range(0, 39) == 0);
            bv = ($urandom_range(0, 3) != 0);
            si = 1'($urandom);
            l  = 1'($urandom);
            r  = ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 15) == 0);
            cycle(fs, bv, si, l, r, c, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
